// File: rtl/tpu_pkg.sv
// +----------------------------------------------------------------------+
// | tpu_pkg : shared state enum, default widths, counter width helper    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package tpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_ARRAY_SIZE = 4;

  // In-flight count can reach 2N, so it needs room for 0..2N.
  function automatic int cnt_width(input int n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_ws.sv
// +----------------------------------------------------------------------+
// | pe_ws : weight-stationary PE, psum_out = psum_in + act * weight      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pe_ws
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wt_load,
  input  logic [DATA_WIDTH-1:0] i_wt,
  input  logic [DATA_WIDTH-1:0] i_act,
  input  logic [ACC_WIDTH-1:0]  i_psum,
  output logic [DATA_WIDTH-1:0] o_act,
  output logic [ACC_WIDTH-1:0]  o_psum
);

  logic signed [DATA_WIDTH-1:0]   r_wt;
  logic        [DATA_WIDTH-1:0]   r_act;
  logic        [ACC_WIDTH-1:0]    r_psum;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic        [ACC_WIDTH-1:0]    w_prod_ext;

  assign w_prod     = $signed(i_act) * r_wt;
  assign w_prod_ext = ACC_WIDTH'(w_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wt   <= '0;
      r_act  <= '0;
      r_psum <= '0;
    end else begin
      if (i_wt_load) begin
        r_wt <= i_wt;
      end
      r_act  <= i_act;
      r_psum <= i_psum + w_prod_ext;
    end
  end

  assign o_act  = r_act;
  assign o_psum = r_psum;

endmodule

`default_nettype wire

// File: rtl/systolic_array_n.sv
// +----------------------------------------------------------------------+
// | systolic_array_n : NxN weight-stationary systolic matrix-vector unit |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module systolic_array_n
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wt_valid,
  output logic                             wt_ready,
  input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] wt_data,
  input  logic                             act_valid,
  output logic                             act_ready,
  input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] act_data,
  input  logic                             act_last,
  output logic                             res_valid,
  output logic [ACC_WIDTH*ARRAY_SIZE-1:0]  res_data,
  output logic                             busy
);

  localparam int N      = ARRAY_SIZE;
  localparam int CNT_W  = cnt_width(ARRAY_SIZE);
  localparam int ROW_W  = $clog2(ARRAY_SIZE);
  localparam int VP_LEN = 2 * ARRAY_SIZE;

  state_e                     r_state;
  state_e                     w_state_nxt;
  logic                       r_wts_loaded;
  logic [ROW_W-1:0]           r_wt_row;
  logic [CNT_W-1:0]           r_inflight;
  logic [VP_LEN-1:0]          r_vpipe;
  logic [ACC_WIDTH*N-1:0]     r_res;
  logic                       w_wt_hs;
  logic                       w_act_hs;
  logic                       w_last_row;
  logic [N-1:0]               w_wt_load;

  logic [DATA_WIDTH-1:0]      w_act_in [N];
  logic [DATA_WIDTH-1:0]      w_act    [N][N+1];
  logic [ACC_WIDTH-1:0]       w_psum   [N+1][N];
  logic [ACC_WIDTH-1:0]       w_col    [N];

  // Weights win over activations in IDLE so a reload is never starved.
  always_comb begin
    wt_ready  = 1'b0;
    act_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        wt_ready  = 1'b1;
        act_ready = r_wts_loaded & ~wt_valid;
      end
      ST_LOAD:  wt_ready  = 1'b1;
      ST_RUN:   act_ready = 1'b1;
      default: begin
        wt_ready  = 1'b0;
        act_ready = 1'b0;
      end
    endcase
  end

  assign w_wt_hs    = wt_valid & wt_ready;
  assign w_act_hs   = act_valid & act_ready;
  assign w_last_row = (r_wt_row == ROW_W'(N - 1));
  assign busy       = (r_state != ST_IDLE);
  assign res_valid  = r_vpipe[VP_LEN-1];
  assign res_data   = r_res;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_wt_hs) begin
          w_state_nxt = ST_LOAD;
        end else if (w_act_hs) begin
          w_state_nxt = act_last ? ST_DRAIN : ST_RUN;
        end
      end
      ST_LOAD: begin
        if (w_wt_hs && w_last_row) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_act_hs && act_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_inflight == '0) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wts_loaded <= 1'b0;
      r_wt_row     <= '0;
      r_inflight   <= '0;
      r_vpipe      <= '0;
    end else begin
      r_state <= w_state_nxt;
      // The first beat clears the flag; only the final beat sets it.
      if (w_wt_hs) begin
        r_wts_loaded <= w_last_row;
        r_wt_row     <= w_last_row ? '0 : r_wt_row + 1'b1;
      end
      case ({w_act_hs, res_valid})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
      r_vpipe <= {r_vpipe[VP_LEN-2:0], w_act_hs};
    end
  end

  // Result register loads one cycle before res_valid rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= '0;
    end else if (r_vpipe[VP_LEN-2]) begin
      for (int j = 0; j < N; j++) begin
        r_res[j*ACC_WIDTH +: ACC_WIDTH] <= w_col[j];
      end
    end
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_row_in
      assign w_act_in[i]  = w_act_hs ? act_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      assign w_wt_load[i] = w_wt_hs && (r_wt_row == ROW_W'(i));

      if (i == 0) begin : g_direct
        assign w_act[0][0] = w_act_in[0];
      end else begin : g_skew
        logic [DATA_WIDTH-1:0] r_sh [i];
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int k = 0; k < i; k++) begin
              r_sh[k] <= '0;
            end
          end else begin
            r_sh[0] <= w_act_in[i];
            for (int k = 1; k < i; k++) begin
              r_sh[k] <= r_sh[k-1];
            end
          end
        end
        assign w_act[i][0] = r_sh[i-1];
      end
    end

    for (genvar j = 0; j < N; j++) begin : g_top_psum
      assign w_psum[0][j] = '0;
    end

    for (genvar i = 0; i < N; i++) begin : g_pe_row
      for (genvar j = 0; j < N; j++) begin : g_pe_col
        pe_ws #(
          .DATA_WIDTH (DATA_WIDTH),
          .ACC_WIDTH  (ACC_WIDTH)
        ) u_pe (
          .clk       (clk),
          .rst_n     (rst_n),
          .i_wt_load (w_wt_load[i]),
          .i_wt      (wt_data[j*DATA_WIDTH +: DATA_WIDTH]),
          .i_act     (w_act[i][j]),
          .i_psum    (w_psum[i][j]),
          .o_act     (w_act[i][j+1]),
          .o_psum    (w_psum[i+1][j])
        );
      end
    end

    // Column j leaves the array j cycles after column 0; delay to align.
    for (genvar j = 0; j < N; j++) begin : g_deskew
      if (j == N - 1) begin : g_direct
        assign w_col[j] = w_psum[N][j];
      end else begin : g_delay
        localparam int D = N - 1 - j;
        logic [ACC_WIDTH-1:0] r_dk [D];
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int k = 0; k < D; k++) begin
              r_dk[k] <= '0;
            end
          end else begin
            r_dk[0] <= w_psum[N][j];
            for (int k = 1; k < D; k++) begin
              r_dk[k] <= r_dk[k-1];
            end
          end
        end
        assign w_col[j] = r_dk[D-1];
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_systolic_array_n.sv
// +----------------------------------------------------------------------+
// | tb_systolic_array_n : table + scoreboard bench, N=4, ACC 32 and 16   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_systolic_array_n;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wt_valid, act_valid, act_last;
  logic [31:0]  wt_data, act_data;
  logic         wt_ready, act_ready, res_valid, busy;
  logic [127:0] res_data;
  logic         wt_ready_b, act_ready_b, res_valid_b, busy_b;
  logic [63:0]  res_data_b;

  always #5 clk = ~clk;

  systolic_array_n #(.DATA_WIDTH(8), .ACC_WIDTH(32), .ARRAY_SIZE(N)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data), .act_last(act_last),
    .res_valid(res_valid), .res_data(res_data), .busy(busy)
  );

  systolic_array_n #(.DATA_WIDTH(8), .ACC_WIDTH(16), .ARRAY_SIZE(N)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .wt_valid(wt_valid), .wt_ready(wt_ready_b), .wt_data(wt_data),
    .act_valid(act_valid), .act_ready(act_ready_b), .act_data(act_data), .act_last(act_last),
    .res_valid(res_valid_b), .res_data(res_data_b), .busy(busy_b)
  );

  typedef struct {
    int                cyc;
    logic [3:0][31:0]  e;
  } sb_t;

  typedef struct {
    logic [31:0]       act;
    logic [3:0][31:0]  exp;
  } tv_t;

  sb_t sb[$];
  sb_t m_it;
  tv_t tbl[6];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  last_res_cyc = -1;
  int  res_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mkv(input int a0, input int a1, input int a2, input int a3);
    return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic logic [3:0][31:0] mke(input int e0, input int e1, input int e2, input int e3);
    logic [3:0][31:0] r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
    return r;
  endfunction

  function automatic logic [63:0] lo16(input logic [3:0][31:0] e);
    logic [63:0] r;
    for (int j = 0; j < N; j++) r[j*16 +: 16] = e[j][15:0];
    return r;
  endfunction

  // Result monitor: every res_valid must match the oldest expected vector.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else if (res_valid) begin
      res_cnt++;
      last_res_cyc = cyc;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_res_valid: got res_valid=1 at cycle %0d expected none", cyc);
      end else begin
        m_it = sb.pop_front();
        check("latency", cyc - m_it.cyc, 2 * N);
        check("res32", res_data, m_it.e);
        check("res16", res_data_b, lo16(m_it.e));
        check("res_valid16", res_valid_b, 1'b1);
      end
    end
  end

  // Tasks are entered just after a rising edge and return just after one.
  task automatic send_wt(input logic [31:0] row);
    bit done = 0;
    wt_valid = 1'b1;
    wt_data  = row;
    for (int t = 0; t < 16 && !done; t++) begin
      @(negedge clk);
      done = wt_ready;
      @(posedge clk); #1;
    end
    wt_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL wt_timeout: got no wt_ready expected handshake");
    end
  endtask

  task automatic send_act(input logic [31:0] a, input logic last, input logic [3:0][31:0] e);
    bit done = 0;
    act_valid = 1'b1;
    act_data  = a;
    act_last  = last;
    for (int t = 0; t < 16 && !done; t++) begin
      @(negedge clk);
      if (act_ready) begin
        sb.push_back('{cyc, e});
        done = 1;
      end
      @(posedge clk); #1;
    end
    act_valid = 1'b0;
    act_last  = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL act_timeout: got no act_ready expected handshake");
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int t = 0; t < 80 && !ok; t++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) ok = 1;
    end
    @(posedge clk); #1;
    check(name, ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fall;
    int hi;
    int cnt0;
    bit drain_ok;

    tbl[0] = '{mkv(1, 2, 3, 4),         mke(5, 6, 7, 9)};
    tbl[1] = '{mkv(-1, -2, -3, -4),     mke(-5, -6, -7, -9)};
    tbl[2] = '{mkv(127, -128, 0, 1),    mke(128, -127, 1, 382)};
    tbl[3] = '{mkv(0, 0, 0, 0),         mke(0, 0, 0, 0)};
    tbl[4] = '{mkv(10, 20, -30, 5),     mke(15, 25, -25, -90)};
    tbl[5] = '{mkv(-128, -128, -128, -128), mke(-256, -256, -256, -512)};

    rst_n = 1'b0; wt_valid = 0; act_valid = 0; act_last = 0; wt_data = '0; act_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wt_ready", wt_ready, 1'b1);
    check("rst_act_ready", act_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, '0);
    check("rst_res_data16", res_data_b, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Identity weights, single vector with act_last.
    send_wt(mkv(1, 0, 0, 0));
    send_wt(mkv(0, 1, 0, 0));
    send_wt(mkv(0, 0, 1, 0));
    send_wt(mkv(0, 0, 0, 1));
    @(negedge clk);
    check("loaded_act_ready", act_ready, 1'b1);
    check("loaded_busy", busy, 1'b0);
    @(posedge clk); #1;
    send_act(mkv(1, 2, 3, 4), 1'b1, mke(1, 2, 3, 4));
    wait_idle("identity_idle");

    // Mixed weights, table vectors back-to-back, last one closes the batch.
    send_wt(mkv(1, 0, 0, 2));
    send_wt(mkv(0, 1, 0, -1));
    send_wt(mkv(0, 0, 1, 3));
    send_wt(mkv(1, 1, 1, 0));
    for (int i = 0; i < 6; i++) begin
      send_act(tbl[i].act, (i == 5), tbl[i].exp);
    end
    drain_ok = 1;
    fall = -1;
    for (int t = 0; t < 40 && fall < 0; t++) begin
      @(negedge clk);
      if (!busy) fall = cyc;
      else if (act_ready || wt_ready) drain_ok = 0;
    end
    check("drain_ready_low", drain_ok, 1'b1);
    check("busy_fall_cycle", fall, last_res_cyc + 2);
    check("table_sb_empty", sb.size(), 0);
    @(posedge clk); #1;

    // All weights -1, activations 127.
    repeat (4) send_wt(32'hFFFF_FFFF);
    send_act(mkv(127, 127, 127, 127), 1'b1, {4{32'hFFFF_FE04}});
    wait_idle("neg_idle");

    // Weight and activation offered together in IDLE: weight wins.
    act_valid = 1'b1; act_data = mkv(1, 1, 1, 1);
    wt_valid  = 1'b1; wt_data  = 32'h7F7F_7F7F;
    @(negedge clk);
    check("prio_act_ready", act_ready, 1'b0);
    check("prio_wt_ready", wt_ready, 1'b1);
    @(posedge clk); #1;
    act_valid = 1'b0; wt_valid = 1'b0;
    @(negedge clk);
    check("prio_busy_load", busy, 1'b1);
    check("prio_load_act_ready", act_ready, 1'b0);
    @(posedge clk); #1;
    repeat (3) send_wt(32'h7F7F_7F7F);
    send_act(mkv(127, 127, 127, 127), 1'b1, {4{32'h0000_FC04}});
    wait_idle("wrap_idle");

    // Reset after two of four weight beats.
    send_wt(mkv(2, 2, 2, 2));
    send_wt(mkv(3, 3, 3, 3));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt0 = res_cnt;
    hi = 0;
    act_valid = 1'b1; act_data = mkv(5, 5, 5, 5);
    repeat (12) begin
      @(negedge clk);
      if (act_ready || act_ready_b) hi++;
    end
    @(posedge clk); #1;
    act_valid = 1'b0;
    check("partial_load_act_ready", hi, 0);
    check("partial_load_no_res", res_cnt - cnt0, 0);

    // Reset with a vector in flight.
    send_wt(mkv(1, 2, 3, 4));
    send_wt(mkv(1, 2, 3, 4));
    send_wt(mkv(1, 2, 3, 4));
    send_wt(mkv(1, 2, 3, 4));
    send_act(mkv(1, 1, 1, 1), 1'b0, mke(4, 8, 12, 16));
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt0 = res_cnt;
    repeat (20) @(negedge clk);
    check("reset_run_no_res", res_cnt - cnt0, 0);
    check("reset_run_idle", busy, 1'b0);
    check("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/systolic_array_n.md
SYSTOLIC_ARRAY_N -- requirements
Module: systolic_array_n

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed activation and weight element width.
- REQ-002 SHALL have parameter ACC_WIDTH, default 32: signed partial-sum and result element width.
- REQ-003 SHALL have parameter ARRAY_SIZE, default 4: array is N x N with N = ARRAY_SIZE, legal range 2..16.
- REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
- REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-006 SHALL have port wt_valid, input, 1 bit, and wt_ready, output, 1 bit: the weight-row handshake.
- REQ-007 SHALL have port wt_data, input, DATA_WIDTH*N bits: one weight row per beat; slice j is the weight W[k][j].
- REQ-008 SHALL have port act_valid, input, 1 bit, and act_ready, output, 1 bit: the activation handshake.
- REQ-009 SHALL have port act_data, input, DATA_WIDTH*N bits: one activation vector; slice i feeds array row i.
- REQ-010 SHALL have port act_last, input, 1 bit: marks the final vector of a batch.
- REQ-011 SHALL have port res_valid, output, 1 bit, and res_data, output, ACC_WIDTH*N bits: the result vector; slice j is column j; there is no backpressure on the result.
- REQ-012 SHALL have port busy, output, 1 bit: high in the LOAD, RUN and DRAIN states.

Function
- REQ-013 SHALL compute res[j] = sum over i of act[i]*W[i][j], using signed operands, with each product sign-extended to ACC_WIDTH and sums wrapping modulo 2^ACC_WIDTH.
- REQ-014 SHALL implement four states: IDLE, LOAD, RUN and DRAIN.
- REQ-015 In IDLE, wt_ready SHALL be 1, and act_ready SHALL equal the weights_loaded flag.
- REQ-016 SHALL give weights priority when in IDLE:
  - When wt_valid=1, act_ready is forced to 0.
  - When wt_valid=1, the first row is accepted and the state becomes LOAD.
- REQ-017 In LOAD, wt_ready SHALL be 1 and act_ready SHALL be 0.
  - Beat k (0..N-1) writes row k of the PE weight registers.
  - After beat N-1: weights_loaded is set to 1 and the state returns to IDLE.
- REQ-018 When a weight load starts, weights_loaded SHALL clear to 0, so a partial load never enables compute.
- REQ-019 An activation handshake in IDLE SHALL move the state to RUN. In RUN, act_ready SHALL be 1 and wt_ready SHALL be 0.
- REQ-020 Accepting a vector with act_last=1 SHALL move the state to DRAIN, from IDLE or from RUN.
  - In DRAIN, act_ready and wt_ready are 0.
  - DRAIN exits to IDLE in the cycle after the in-flight count reaches 0.
- REQ-021 SHALL skew the input: row i is delayed by i cycles through a shift register before entering PE[i][0].
- REQ-022 SHALL move data one PE per cycle: activations pass one PE right per cycle, and partial sums pass one PE down per cycle through a registered output.
- REQ-023 SHALL de-skew the output: column j from the bottom row is delayed by N-1-j cycles, so all N results align.
- REQ-024 SHALL assert res_valid for exactly one cycle, exactly 2*N cycles after each act handshake cycle.
- REQ-025 SHALL deliver back-to-back accepted vectors as back-to-back results at 1 vector per cycle.
- REQ-026 SHALL hold res_data stable when res_valid=0; its value in that case is don't-care but deterministic.
- REQ-027 SHALL track in-flight vectors with a counter of ceil(log2(2N+1)) bits.
  - It increments on accept and decrements on res_valid.
  - It is unchanged when both happen in the same cycle.
- REQ-028 SHALL ignore wt_valid outside IDLE/LOAD, and act_valid outside IDLE/RUN; no state changes in either case.

Reset
- REQ-029 SHALL force the following while rst_n=0:
  - state = IDLE and weights_loaded = 0;
  - all PE weights, skew registers, de-skew registers, the valid pipeline and the counters = 0;
  - res_valid = 0, res_data = 0 and busy = 0;
  - wt_ready = 1 and act_ready = 0.
- REQ-030 Reset mid-LOAD or mid-RUN SHALL discard all partial weights and in-flight results; no res_valid follows reset release.

Structure
- REQ-031 SHALL import the state enum, default widths and a clog2-based counter width function from the shared package tpu_pkg.
- REQ-032 SHALL instantiate one sub-module, pe_ws, N*N times using generate loops.
  - pe_ws holds a stationary weight with a load enable.
  - pe_ws has a registered act_out and a registered psum_out.

Verification (N=4, DATA_WIDTH=8, ACC_WIDTH=32 unless stated)
- REQ-033 Identity weights; act [1,2,3,4] with act_last -> res_valid 8 cycles later; res = [1,2,3,4]; state returns to IDLE.
- REQ-034 All weights -1 (0xFF); act [127,127,127,127] -> every column = -508 (0xFFFFFE04).
- REQ-035 Four back-to-back vectors, act_last on the 4th:
  - four consecutive res_valid cycles with correct sums;
  - act_ready = 0 throughout DRAIN;
  - busy falls after the last result.
- REQ-036 Reset asserted after 2 of 4 weight beats, then act_valid=1 -> act_ready stays 0 and there is no res_valid.
- REQ-037 In IDLE with weights loaded, wt_valid=1 and act_valid=1 in the same cycle -> weight accepted, act_ready = 0, state = LOAD.
- REQ-038 ACC_WIDTH=16, all weights 127, act all 127 -> each column = 0xFC04 (modulo wrap).
